// File: rtl/mem_boot_ctrl.sv
// mem_boot_ctrl: streams host words into the data BRAM, then the instruction BRAM, then releases the core.
// Optional feature macro BOOT_CHECKSUM_EN adds a trailing checksum beat (CHECK state) and an ERROR outcome.
module mem_boot_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic [ADDR_WIDTH-2:0] cfg_d_words_i,
  input  logic [ADDR_WIDTH-2:0] cfg_i_words_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  input  logic                  halt_i,
  output logic [ADDR_WIDTH-1:0] i_w_addr_o,
  output logic [DATA_WIDTH-1:0] i_w_dat_o,
  output logic                  i_w_enb_o,
  output logic [3:0]            i_w_byte_enb_o,
  output logic [ADDR_WIDTH-1:0] d_w_addr_o,
  output logic [DATA_WIDTH-1:0] d_w_dat_o,
  output logic                  d_w_enb_o,
  output logic [3:0]            d_w_byte_enb_o,
  output logic                  pc_stall_o,
  output logic                  i_r_enb_o,
  output logic                  rd_enbl_o,
  output logic                  d_bram_init_done_o,
  output logic                  boot_err_o
);

  localparam int CNT_W = ADDR_WIDTH - 1;
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << IDX_W;

  // IDLE wait cfg | LOAD_D/LOAD_I stream words | CHECK checksum beat | RUN core live | ERROR bad sum
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_D = 3'd1,
    ST_LOAD_I = 3'd2,
`ifdef BOOT_CHECKSUM_EN
    ST_CHECK  = 3'd3,
`endif
    ST_RUN    = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t ST_POST = ST_CHECK;
`else
  localparam state_t ST_POST = ST_RUN;
`endif

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  state_t state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, i_cnt_q, i_cnt_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic run_arm_q;
  logic d_w_enb_q, d_w_enb_d, i_w_enb_q, i_w_enb_d;
  logic [ADDR_WIDTH-1:0] d_w_addr_q, d_w_addr_d, i_w_addr_q, i_w_addr_d;
  logic [DATA_WIDTH-1:0] d_w_dat_q, d_w_dat_d, i_w_dat_q, i_w_dat_d;
  logic [CNT_W-1:0] d_clamp, i_clamp;
  logic start_ok, accept, last_beat, loading, released;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  assign d_clamp   = clamp_cnt(cfg_d_words_i);
  assign i_clamp   = clamp_cnt(cfg_i_words_i);
  assign start_ok  = cfg_start_i && (state_q == ST_IDLE || state_q == ST_ERROR);
  assign accept    = s_valid_i && s_ready_o;
  assign last_beat = (rem_q == CNT_W'(1));
  assign loading   = (state_q == ST_LOAD_D) || (state_q == ST_LOAD_I);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (cfg_start_i) begin
          if (d_clamp != '0)      state_d = ST_LOAD_D;
          else if (i_clamp != '0) state_d = ST_LOAD_I;
          else                    state_d = ST_POST;
        end
      end
      ST_LOAD_D: if (accept && last_beat) state_d = (i_cnt_q != '0) ? ST_LOAD_I : ST_POST;
      ST_LOAD_I: if (accept && last_beat) state_d = ST_POST;
`ifdef BOOT_CHECKSUM_EN
      ST_CHECK:  if (accept) state_d = (sum_q == s_data_i) ? ST_RUN : ST_ERROR;
`endif
      ST_RUN:    if (halt_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Release is held off one cycle in RUN so the final BRAM write lands while the core is still stalled.
  always_comb begin
    s_ready_o = 1'b0;
    released  = 1'b0;
    case (state_q)
      ST_LOAD_D, ST_LOAD_I: s_ready_o = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      ST_CHECK:             s_ready_o = 1'b1;
`endif
      ST_RUN:               released  = run_arm_q;
      default:              ;
    endcase
  end

  assign pc_stall_o         = ~released;
  assign i_r_enb_o          = released;
  assign rd_enbl_o          = released;
  assign d_bram_init_done_o = released;

  always_comb begin
    rem_d      = rem_q;
    k_d        = k_q;
    i_cnt_d    = i_cnt_q;
    d_w_enb_d  = 1'b0;
    i_w_enb_d  = 1'b0;
    d_w_addr_d = d_w_addr_q;
    d_w_dat_d  = d_w_dat_q;
    i_w_addr_d = i_w_addr_q;
    i_w_dat_d  = i_w_dat_q;
    if (start_ok) begin
      i_cnt_d = i_clamp;
      rem_d   = (d_clamp != '0) ? d_clamp : i_clamp;
      k_d     = '0;
    end else if (accept && loading) begin
      if (state_q == ST_LOAD_D) begin
        d_w_enb_d  = 1'b1;
        d_w_addr_d = {k_q, 2'b00};
        d_w_dat_d  = s_data_i;
      end else begin
        i_w_enb_d  = 1'b1;
        i_w_addr_d = {k_q, 2'b00};
        i_w_dat_d  = s_data_i;
      end
      if (last_beat) begin
        rem_d = i_cnt_q;
        k_d   = '0;
      end else begin
        rem_d = rem_q - CNT_W'(1);
        k_d   = k_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q      <= '0;
      k_q        <= '0;
      i_cnt_q    <= '0;
      run_arm_q  <= 1'b0;
      d_w_enb_q  <= 1'b0;
      i_w_enb_q  <= 1'b0;
      d_w_addr_q <= '0;
      d_w_dat_q  <= '0;
      i_w_addr_q <= '0;
      i_w_dat_q  <= '0;
    end else begin
      rem_q      <= rem_d;
      k_q        <= k_d;
      i_cnt_q    <= i_cnt_d;
      run_arm_q  <= (state_q == ST_RUN);
      d_w_enb_q  <= d_w_enb_d;
      i_w_enb_q  <= i_w_enb_d;
      d_w_addr_q <= d_w_addr_d;
      d_w_dat_q  <= d_w_dat_d;
      i_w_addr_q <= i_w_addr_d;
      i_w_dat_q  <= i_w_dat_d;
    end
  end

  assign d_w_enb_o      = d_w_enb_q;
  assign d_w_addr_o     = d_w_addr_q;
  assign d_w_dat_o      = d_w_dat_q;
  assign d_w_byte_enb_o = {4{d_w_enb_q}};
  assign i_w_enb_o      = i_w_enb_q;
  assign i_w_addr_o     = i_w_addr_q;
  assign i_w_dat_o      = i_w_dat_q;
  assign i_w_byte_enb_o = {4{i_w_enb_q}};

`ifdef BOOT_CHECKSUM_EN
  always_comb begin
    sum_d = sum_q;
    if (start_ok)              sum_d = '0;
    else if (accept && loading) sum_d = sum_q + s_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign boot_err_o = (state_q == ST_ERROR);
`else
  assign boot_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Self-checking bench for mem_boot_ctrl: random word streams checked against a queue-based load model.
`timescale 1ns/1ps
module tb_mem_boot_ctrl;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int CW   = AW - 1;
  localparam int MAXW = 1 << (AW - 2);

  logic          clk_i = 1'b0, rst_i = 1'b1, cfg_start_i = 1'b0, s_valid_i = 1'b0, halt_i = 1'b0;
  logic [CW-1:0] cfg_d_words_i = '0, cfg_i_words_i = '0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o, i_w_enb_o, d_w_enb_o, pc_stall_o, i_r_enb_o, rd_enbl_o;
  logic          d_bram_init_done_o, boot_err_o;
  logic [AW-1:0] i_w_addr_o, d_w_addr_o;
  logic [DW-1:0] i_w_dat_o, d_w_dat_o;
  logic [3:0]    i_w_byte_enb_o, d_w_byte_enb_o;

  always #5 clk_i = ~clk_i;

  mem_boot_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_start_i(cfg_start_i),
    .cfg_d_words_i(cfg_d_words_i), .cfg_i_words_i(cfg_i_words_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o), .halt_i(halt_i),
    .i_w_addr_o(i_w_addr_o), .i_w_dat_o(i_w_dat_o), .i_w_enb_o(i_w_enb_o), .i_w_byte_enb_o(i_w_byte_enb_o),
    .d_w_addr_o(d_w_addr_o), .d_w_dat_o(d_w_dat_o), .d_w_enb_o(d_w_enb_o), .d_w_byte_enb_o(d_w_byte_enb_o),
    .pc_stall_o(pc_stall_o), .i_r_enb_o(i_r_enb_o), .rd_enbl_o(rd_enbl_o),
    .d_bram_init_done_o(d_bram_init_done_o), .boot_err_o(boot_err_o)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] dat; int cyc; } wr_t;

  wr_t           d_got[$], i_got[$];
  int            acc_q[$], rel_q[$];
  int            cyc = 0, viol = 0, n_vec = 0, n_bad = 0, pulse_cyc = 0;
  logic          prev_stall = 1'b1, prev_done = 1'b0;
  logic [DW-1:0] tx_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Passive monitor: logs writes, accepted beats, release edges and protocol invariants.
  always @(negedge clk_i) begin
    wr_t w;
    if (d_w_enb_o) begin w.addr = d_w_addr_o; w.dat = d_w_dat_o; w.cyc = cyc; d_got.push_back(w); end
    if (i_w_enb_o) begin w.addr = i_w_addr_o; w.dat = i_w_dat_o; w.cyc = cyc; i_got.push_back(w); end
    if (d_w_byte_enb_o !== (d_w_enb_o ? 4'hF : 4'h0)) viol = viol + 1;
    if (i_w_byte_enb_o !== (i_w_enb_o ? 4'hF : 4'h0)) viol = viol + 1;
    if (d_bram_init_done_o !== prev_done && d_w_enb_o) viol = viol + 1;
    if (s_valid_i && s_ready_o) acc_q.push_back(cyc);
    if (prev_stall && !pc_stall_o) rel_q.push_back(cyc);
    prev_done  = d_bram_init_done_o;
    prev_stall = pc_stall_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input int dn, input int in);
    cfg_d_words_i = CW'(dn);
    cfg_i_words_i = CW'(in);
    cfg_start_i   = 1'b1;
    @(negedge clk_i);
    pulse_cyc = cyc;
    @(posedge clk_i); #1;
    cfg_start_i = 1'b0;
  endtask

  task automatic stream(input int mode, input string tag);
    int idx = 0;
    int budget = 0;
    int lim;
    lim = 4 * tx_q.size() + 20;
    while (idx < tx_q.size() && budget < lim) begin
      case (mode)
        1:       s_valid_i = (budget % 2 == 0);
        2:       s_valid_i = ($urandom_range(0, 1) == 1);
        default: s_valid_i = 1'b1;
      endcase
      s_data_i = s_valid_i ? tx_q[idx] : $urandom;
      @(negedge clk_i);
      if (s_valid_i && s_ready_o) idx++;
      @(posedge clk_i); #1;
      budget++;
    end
    s_valid_i = 1'b0;
    n_vec++;
    if (idx != tx_q.size()) begin
      n_bad++;
      $display("FAIL %s stream_timeout: accepted %0d beats, required %0d", tag, idx, tx_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i); #1;
    @(negedge clk_i);
    n_vec++;
    if ({pc_stall_o, s_ready_o, d_bram_init_done_o, boot_err_o, i_r_enb_o, rd_enbl_o} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, required 100000",
               {pc_stall_o, s_ready_o, d_bram_init_done_o, boot_err_o, i_r_enb_o, rd_enbl_o});
    end
    n_vec++;
    if ({d_w_enb_o, i_w_enb_o, d_w_byte_enb_o, i_w_byte_enb_o} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_enables: got %b, required 0", {d_w_enb_o, i_w_enb_o, d_w_byte_enb_o, i_w_byte_enb_o});
    end
    n_vec++;
    if ({d_w_addr_o, i_w_addr_o, d_w_dat_o, i_w_dat_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_addr_dat: got d_addr=%h i_addr=%h d_dat=%h i_dat=%h, required 0",
               d_w_addr_o, i_w_addr_o, d_w_dat_o, i_w_dat_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic run_load(input int dn, input int in, input int mode, input string tag);
    int de, ie, mark, v0, first_acc, last_acc, rel, exp_rel, first_wr, last_wr;
    wr_t dw[$];
    wr_t iw[$];
    logic [DW-1:0] sum;
    de  = (dn > MAXW) ? MAXW : dn;
    ie  = (in > MAXW) ? MAXW : in;
    sum = '0;
    tx_q.delete();
    for (int k = 0; k < de + ie; k++) begin
      tx_q.push_back($urandom);
      sum += tx_q[k];
    end
`ifdef BOOT_CHECKSUM_EN
    tx_q.push_back(sum);
`endif
    mark = cyc;
    v0   = viol;
    pulse_start(dn, in);
    stream(mode, tag);
    repeat (4) @(posedge clk_i); #1;
    @(negedge clk_i);
    n_vec++;
    if ({pc_stall_o, d_bram_init_done_o, i_r_enb_o, rd_enbl_o, s_ready_o} !== 5'b01110) begin
      n_bad++;
      $display("FAIL %s run_outputs: got stall/done/ire/rd/rdy=%b, required 01110", tag,
               {pc_stall_o, d_bram_init_done_o, i_r_enb_o, rd_enbl_o, s_ready_o});
    end
    foreach (d_got[j]) if (d_got[j].cyc > mark) dw.push_back(d_got[j]);
    foreach (i_got[j]) if (i_got[j].cyc > mark) iw.push_back(i_got[j]);
    first_acc = -1; last_acc = -1; rel = -1;
    foreach (acc_q[j]) if (acc_q[j] > mark) begin
      if (first_acc < 0) first_acc = acc_q[j];
      last_acc = acc_q[j];
    end
    foreach (rel_q[j]) if (rel_q[j] > mark) rel = rel_q[j];
    n_vec++;
    if (dw.size() != de) begin
      n_bad++;
      $display("FAIL %s d_write_count: got %0d, required %0d", tag, dw.size(), de);
    end
    for (int k = 0; k < de && k < dw.size(); k++) begin
      n_vec++;
      if (dw[k].addr !== AW'(k * 4) || dw[k].dat !== tx_q[k]) begin
        n_bad++;
        $display("FAIL %s d_write[%0d]: got addr=%h dat=%h, required addr=%h dat=%h",
                 tag, k, dw[k].addr, dw[k].dat, AW'(k * 4), tx_q[k]);
      end
    end
    n_vec++;
    if (iw.size() != ie) begin
      n_bad++;
      $display("FAIL %s i_write_count: got %0d, required %0d", tag, iw.size(), ie);
    end
    for (int k = 0; k < ie && k < iw.size(); k++) begin
      n_vec++;
      if (iw[k].addr !== AW'(k * 4) || iw[k].dat !== tx_q[de + k]) begin
        n_bad++;
        $display("FAIL %s i_write[%0d]: got addr=%h dat=%h, required addr=%h dat=%h",
                 tag, k, iw[k].addr, iw[k].dat, AW'(k * 4), tx_q[de + k]);
      end
    end
    exp_rel = (last_acc >= 0) ? last_acc + 2 : pulse_cyc + 2;
    n_vec++;
    if (rel != exp_rel) begin
      n_bad++;
      $display("FAIL %s release_cycle: got %0d, required %0d", tag, rel, exp_rel);
    end
    n_vec++;
    if (viol != v0) begin
      n_bad++;
      $display("FAIL %s invariants: got %0d byte-enable/handover violations, required 0", tag, viol - v0);
    end
    if (dw.size() == de && iw.size() == ie && de + ie > 0) begin
      first_wr = (de > 0) ? dw[0].cyc : iw[0].cyc;
      last_wr  = (ie > 0) ? iw[ie-1].cyc : dw[de-1].cyc;
      n_vec++;
      if (first_wr != first_acc + 1) begin
        n_bad++;
        $display("FAIL %s write_latency: first write cycle %0d, required %0d", tag, first_wr, first_acc + 1);
      end
      if (mode == 0) begin
        n_vec++;
        if (first_acc != pulse_cyc + 1) begin
          n_bad++;
          $display("FAIL %s ready_latency: first accept cycle %0d, required %0d", tag, first_acc, pulse_cyc + 1);
        end
        n_vec++;
        if (last_wr - first_wr != de + ie - 1) begin
          n_bad++;
          $display("FAIL %s back_to_back: write span %0d cycles, required %0d", tag, last_wr - first_wr, de + ie - 1);
        end
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_start_ignored();
    int mark, nw;
    mark = cyc;
    pulse_start(5, 5);
    @(negedge clk_i);
    n_vec++;
    if ({s_ready_o, pc_stall_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL start_in_run: got ready/stall=%b, required 00", {s_ready_o, pc_stall_o});
    end
    repeat (2) @(posedge clk_i); #1;
    nw = 0;
    foreach (d_got[j]) if (d_got[j].cyc > mark) nw++;
    foreach (i_got[j]) if (i_got[j].cyc > mark) nw++;
    n_vec++;
    if (nw != 0) begin
      n_bad++;
      $display("FAIL start_in_run_writes: got %0d writes, required 0", nw);
    end
  endtask

  task automatic do_halt(input string tag);
    halt_i = 1'b1;
    @(posedge clk_i); #1;
    halt_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({pc_stall_o, d_bram_init_done_o, i_r_enb_o, rd_enbl_o, s_ready_o} !== 5'b10000) begin
      n_bad++;
      $display("FAIL %s halt: got stall/done/ire/rd/rdy=%b, required 10000", tag,
               {pc_stall_o, d_bram_init_done_o, i_r_enb_o, rd_enbl_o, s_ready_o});
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_midload();
    int mark, rmark, got, budget, nb, na;
    tx_q.delete();
    for (int k = 0; k < 4; k++) tx_q.push_back($urandom);
    mark = cyc;
    pulse_start(4, 0);
    got = 0; budget = 0;
    while (got < 2 && budget < 20) begin
      s_valid_i = 1'b1;
      s_data_i  = tx_q[got];
      @(negedge clk_i);
      if (s_ready_o) got++;
      @(posedge clk_i); #1;
      budget++;
    end
    rst_i     = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = tx_q[2];
    @(posedge clk_i); #1;
    rst_i     = 1'b0;
    s_valid_i = 1'b0;
    rmark     = cyc;
    @(negedge clk_i);
    n_vec++;
    if ({pc_stall_o, s_ready_o, d_w_enb_o, i_w_enb_o, d_bram_init_done_o, d_w_byte_enb_o} !== 9'b100000000) begin
      n_bad++;
      $display("FAIL rst_midload_state: got stall/rdy/denb/ienb/done/dbe=%b, required 100000000",
               {pc_stall_o, s_ready_o, d_w_enb_o, i_w_enb_o, d_bram_init_done_o, d_w_byte_enb_o});
    end
    repeat (3) @(posedge clk_i); #1;
    nb = 0; na = 0;
    foreach (d_got[j]) begin
      if (d_got[j].cyc > mark && d_got[j].cyc < rmark) nb++;
      if (d_got[j].cyc >= rmark) na++;
    end
    n_vec++;
    if (nb != 2 || na != 0) begin
      n_bad++;
      $display("FAIL rst_midload_writes: got %0d before / %0d after reset, required 2 / 0", nb, na);
    end
    run_load(3, 1, 0, "reload");
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    tx_q.delete();
    tx_q.push_back(32'd1); tx_q.push_back(32'd2); tx_q.push_back(32'd3); tx_q.push_back(32'd7);
    pulse_start(3, 0);
    stream(0, "chk_bad");
    repeat (3) @(posedge clk_i); #1;
    @(negedge clk_i);
    n_vec++;
    if ({boot_err_o, pc_stall_o, s_ready_o, d_bram_init_done_o} !== 4'b1100) begin
      n_bad++;
      $display("FAIL chk_bad: got err/stall/rdy/done=%b, required 1100",
               {boot_err_o, pc_stall_o, s_ready_o, d_bram_init_done_o});
    end
    @(posedge clk_i); #1;
    tx_q.delete();
    tx_q.push_back(32'd1); tx_q.push_back(32'd2); tx_q.push_back(32'd3); tx_q.push_back(32'd6);
    pulse_start(0, 3);
    stream(0, "chk_good");
    repeat (3) @(posedge clk_i); #1;
    @(negedge clk_i);
    n_vec++;
    if ({boot_err_o, pc_stall_o, d_bram_init_done_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL chk_good: got err/stall/done=%b, required 001", {boot_err_o, pc_stall_o, d_bram_init_done_o});
    end
    @(posedge clk_i); #1;
  endtask
`endif

  initial begin
    test_reset();
    run_load(4, 3, 0, "basic");
    test_start_ignored();
    do_halt("halt_basic");
    run_load(4, 3, 1, "bubbles");
    do_halt("halt_bubbles");
    run_load(0, 2, 0, "zero_d");
    do_halt("halt_zero_d");
    run_load(0, 0, 0, "zero_both");
    do_halt("halt_zero_both");
    run_load(3, 0, 1, "zero_i");
    do_halt("halt_zero_i");
    for (int r = 0; r < 6; r++) begin
      run_load($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 2), "random");
      do_halt("halt_random");
    end
    run_load(2047, 1, 0, "clamp");
    do_halt("halt_clamp");
    test_reset_midload();
`ifdef BOOT_CHECKSUM_EN
    do_halt("halt_pre_chk");
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_boot_ctrl.md
# mem_boot_ctrl

Boot sequencer for the rv32i_sc core. It takes a word stream from a host, such as a UART bridge or the bench, and writes it into the data BRAM and then the instruction BRAM. It holds the core stalled while loading, then hands the data-BRAM write port to the datapath and releases the core. It replaces hand-sequenced bench loading and drives the PC stall, the BRAM read enables and the data-BRAM port select.

## Interface
Parameters:
- ADDR_WIDTH, 12, BRAM byte-address width.
- DATA_WIDTH, 32, word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; latch counts and begin loading.
- cfg_d_words  in  ADDR_WIDTH-1  number of data words to load.
- cfg_i_words  in  ADDR_WIDTH-1  number of instruction words to load.
- s_valid  in  1  host word valid.
- s_data  in  DATA_WIDTH  host word.
- s_ready  out  1  controller accepts word.
- halt  in  1  in RUN: stop the core and return to IDLE.
- i_w_addr / d_w_addr  out  ADDR_WIDTH  BRAM write byte address.
- i_w_dat / d_w_dat  out  DATA_WIDTH  BRAM write data.
- i_w_enb / d_w_enb  out  1  BRAM write enable.
- i_w_byte_enb / d_w_byte_enb  out  4  byte enables; 4'b1111 when writing, else 4'b0000.
- pc_stall  out  1  PC stall.
- i_r_enb  out  1  instruction BRAM read enable.
- rd_enbl  out  1  register-file read enable.
- d_bram_init_done  out  1  1 = datapath owns the data-BRAM write port.
- boot_err  out  1  checksum mismatch (macro only; otherwise tied 0).

## Operation
- States: IDLE, LOAD_D, LOAD_I, CHECK (macro only), RUN, ERROR.
- IDLE:
  - s_ready=0, pc_stall=1, reads disabled, d_bram_init_done=0.
  - On cfg_start, latch the counts. Values above 2^(ADDR_WIDTH-2) clamp to 2^(ADDR_WIDTH-2).
  - Go to LOAD_D if the data count is nonzero, else LOAD_I if the instruction count is nonzero, else the post-load state.
- LOAD_D / LOAD_I:
  - s_ready=1. A beat is accepted when s_valid&&s_ready.
  - Word index k starts at 0. Write address = k*4, with the low 2 bits always 0.
  - After the final beat, the data segment moves to LOAD_I, or skips it if the instruction count is 0. The index restarts at 0.
  - s_valid low inserts bubbles with no write and no state change.
- Post-load state is CHECK with BOOT_CHECKSUM_EN, otherwise RUN.
- RUN:
  - pc_stall=0, i_r_enb=1, rd_enbl=1, d_bram_init_done=1, s_ready=0.
  - halt: next cycle IDLE, pc_stall=1, d_bram_init_done=0.
- cfg_start outside IDLE/ERROR is ignored. halt outside RUN is ignored.
- ERROR:
  - pc_stall=1, boot_err=1, s_ready=0.
  - cfg_start restarts loading as from IDLE and clears boot_err.

## Timing
- Reset values:
  - pc_stall=1.
  - All enables, ready, d_bram_init_done and boot_err = 0.
  - Addresses, data and byte enables = 0.
  - State = IDLE.
- Write outputs are registered. A beat accepted in cycle N appears as enb=1 with its addr/dat in cycle N+1 for exactly one cycle.
- Back-to-back valid beats give one write per cycle.
- The IDLE→LOAD transition takes 1 cycle after cfg_start. s_ready rises the cycle after the pulse.
- The final-beat write (cycle N+1) completes before the core is released. The RUN outputs take effect in cycle N+2 at the earliest.
- d_bram_init_done changes only in a cycle with d_w_enb=0.
- rst mid-load: the next cycle is the full reset state. A partial load is abandoned with no further writes.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - A 32-bit modulo-2^32 running sum covers every accepted payload word in both segments. It clears on cfg_start.
  - After the payload, CHECK asserts s_ready for one extra beat, which is not written to any BRAM.
  - On match, go to RUN. On mismatch, go to ERROR.
- Undefined: no CHECK state, no sum logic, boot_err tied 0, and the post-load state is RUN.

## Test plan
- Basic load:
  - Stimulus: cfg_d_words=4, cfg_i_words=3, stream words continuously.
  - Response: d_w_addr 0x0,0x4,0x8,0xC, then i_w_addr 0x0,0x4,0x8, one write per cycle with byte_enb=4'b1111. pc_stall falls 2 cycles after the last beat, with d_bram_init_done=1.
- Bubbles:
  - Stimulus: deassert s_valid every other cycle.
  - Response: same addresses and data, with no writes on idle cycles.
- Zero counts:
  - Stimulus: cfg_d_words=0, cfg_i_words=2.
  - Response: no d_w_enb pulses, and i_w_addr goes 0x0,0x4.
  - Stimulus: both counts 0.
  - Response: RUN with no writes (macro off).
- Reset mid-load:
  - Stimulus: rst after 2 of 4 data beats.
  - Response: the next cycle has pc_stall=1, s_ready=0 and no enables. A fresh cfg_start reloads from address 0x0.
- Halt and reload:
  - Stimulus: halt in RUN.
  - Response: pc_stall=1 and d_bram_init_done=0 the next cycle. cfg_start is accepted.
- Checksum (macro on):
  - Stimulus: words 1,2,3 with checksum word 0x6.
  - Response: RUN.
  - Stimulus: checksum word 0x7.
  - Response: ERROR with boot_err=1 and pc_stall held at 1.
